// File: rtl/bel_fft_mif_arb_pkg.sv
// ---------------------------------------------------------------------------
// bel_fft_mif_arb_pkg
//   Shared constants and types for the FFT memory-interface arbiter:
//   - BEL_FFT_AWIDTH : default complex-sample address width
//   - BEL_ARB_NREQ   : number of arbitrated requesters
//   - arb_state_t    : arbiter FSM state encoding
// ---------------------------------------------------------------------------
package bel_fft_mif_arb_pkg;

    localparam int BEL_FFT_AWIDTH = 10;
    localparam int BEL_ARB_NREQ   = 4;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/bel_fft_rr_pick.sv
// ---------------------------------------------------------------------------
// bel_fft_rr_pick
//   Combinational 4-way round-robin selector. Searches the requests in the
//   order last+1, last+2, last+3, last (mod 4) and returns the first hit.
//
//   Ports:
//     req  in  [3:0]  request vector
//     last in  [1:0]  index of the most recently served requester
//     idx  out [1:0]  selected requester (0 when nothing is requesting)
//     any  out        at least one request is pending
// ---------------------------------------------------------------------------
module bel_fft_rr_pick
    import bel_fft_mif_arb_pkg::*;
(
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] idx,
    output logic       any
);

    // Candidate index and hit flag for each search position.
    logic [1:0] cand [4];
    logic [3:0] hit;

    generate
        for (genvar gi = 0; gi < BEL_ARB_NREQ; gi++) begin : g_cand
            assign cand[gi] = last + 2'(gi + 1);
            assign hit[gi]  = req[cand[gi]];
        end
    endgenerate

    // Highest search position scanned first so that position 0 (last+1)
    // ends up with the final say.
    always_comb begin
        idx = 2'd0;
        for (int i = BEL_ARB_NREQ - 1; i >= 0; i--) begin
            if (hit[i]) begin
                idx = cand[i];
            end
        end
    end

    assign any = |req;

endmodule

// File: rtl/bel_fft_mif_arb.sv
// ---------------------------------------------------------------------------
// bel_fft_mif_arb
//   Round-robin arbiter serialising four complex-sample requesters onto a
//   single memory-interface port. One IDLE cycle picks a winner; the GRANT
//   state forwards that requester combinationally until the memory acks.
//
//   Ports:
//     clk_i, rst_i                      clock, asynchronous active-high reset
//     req_adr<k>_i / req_re<k>_i /
//     req_im<k>_i                       requester k address and write data
//     req_wr<k>_i / req_rd<k>_i         requester k write / read request
//     req_ack<k>_o                      requester k acknowledge
//     rd_re_o / rd_im_o                 read data broadcast (valid with ack)
//     adr_o, dat_re_o, dat_im_o,
//     wr_o, rd_o                        forwarded access to the MIF port
//     ack_i, dat_re_i, dat_im_i         MIF acknowledge and read data
//     err_o                             sticky protocol-violation flag
// ---------------------------------------------------------------------------
module bel_fft_mif_arb
    import bel_fft_mif_arb_pkg::*;
#(
    parameter int word_width = 32,
    parameter int adr_width  = BEL_FFT_AWIDTH
) (
    input  logic                  clk_i,
    input  logic                  rst_i,

    input  logic [adr_width-1:0]  req_adr0_i,
    input  logic [word_width-1:0] req_re0_i,
    input  logic [word_width-1:0] req_im0_i,
    input  logic                  req_wr0_i,
    input  logic                  req_rd0_i,
    output logic                  req_ack0_o,

    input  logic [adr_width-1:0]  req_adr1_i,
    input  logic [word_width-1:0] req_re1_i,
    input  logic [word_width-1:0] req_im1_i,
    input  logic                  req_wr1_i,
    input  logic                  req_rd1_i,
    output logic                  req_ack1_o,

    input  logic [adr_width-1:0]  req_adr2_i,
    input  logic [word_width-1:0] req_re2_i,
    input  logic [word_width-1:0] req_im2_i,
    input  logic                  req_wr2_i,
    input  logic                  req_rd2_i,
    output logic                  req_ack2_o,

    input  logic [adr_width-1:0]  req_adr3_i,
    input  logic [word_width-1:0] req_re3_i,
    input  logic [word_width-1:0] req_im3_i,
    input  logic                  req_wr3_i,
    input  logic                  req_rd3_i,
    output logic                  req_ack3_o,

    output logic [word_width-1:0] rd_re_o,
    output logic [word_width-1:0] rd_im_o,

    output logic [adr_width-1:0]  adr_o,
    output logic [word_width-1:0] dat_re_o,
    output logic [word_width-1:0] dat_im_o,
    output logic                  wr_o,
    output logic                  rd_o,
    input  logic                  ack_i,
    input  logic [word_width-1:0] dat_re_i,
    input  logic [word_width-1:0] dat_im_i,

    output logic                  err_o
);

    // Requester inputs gathered into indexable arrays.
    logic [adr_width-1:0]  adr_arr [BEL_ARB_NREQ];
    logic [word_width-1:0] re_arr  [BEL_ARB_NREQ];
    logic [word_width-1:0] im_arr  [BEL_ARB_NREQ];
    logic [3:0]            wr_vec;
    logic [3:0]            rd_vec;
    logic [3:0]            req_vec;
    logic [3:0]            ack_vec;

    assign adr_arr[0] = req_adr0_i;
    assign adr_arr[1] = req_adr1_i;
    assign adr_arr[2] = req_adr2_i;
    assign adr_arr[3] = req_adr3_i;
    assign re_arr[0]  = req_re0_i;
    assign re_arr[1]  = req_re1_i;
    assign re_arr[2]  = req_re2_i;
    assign re_arr[3]  = req_re3_i;
    assign im_arr[0]  = req_im0_i;
    assign im_arr[1]  = req_im1_i;
    assign im_arr[2]  = req_im2_i;
    assign im_arr[3]  = req_im3_i;
    assign wr_vec     = {req_wr3_i, req_wr2_i, req_wr1_i, req_wr0_i};
    assign rd_vec     = {req_rd3_i, req_rd2_i, req_rd1_i, req_rd0_i};

    generate
        for (genvar gi = 0; gi < BEL_ARB_NREQ; gi++) begin : g_req
            assign req_vec[gi] = wr_vec[gi] | rd_vec[gi];
        end
    endgenerate

    assign req_ack0_o = ack_vec[0];
    assign req_ack1_o = ack_vec[1];
    assign req_ack2_o = ack_vec[2];
    assign req_ack3_o = ack_vec[3];

    // Read data is a plain broadcast; each requester qualifies it with its ack.
    assign rd_re_o = dat_re_i;
    assign rd_im_o = dat_im_i;

    arb_state_t state_reg, state_next;
    logic [1:0] grant_reg, grant_next;
    logic [1:0] last_reg,  last_next;
    logic       err_reg,   err_next;
    logic [1:0] pick_idx;
    logic       pick_any;

    bel_fft_rr_pick u_pick (
        .req  (req_vec),
        .last (last_reg),
        .idx  (pick_idx),
        .any  (pick_any)
    );

    // last resets to 3 so the first winner after reset is requester 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ARB_IDLE;
            grant_reg <= 2'd0;
            last_reg  <= 2'd3;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            last_reg  <= last_next;
            err_reg   <= err_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        last_next  = last_reg;
        err_next   = err_reg;
        wr_o       = 1'b0;
        rd_o       = 1'b0;
        adr_o      = '0;
        dat_re_o   = '0;
        dat_im_o   = '0;
        ack_vec    = 4'b0000;

        case (state_reg)
            ARB_IDLE: begin
                // A memory ack with nothing forwarded is a protocol fault.
                if (ack_i) begin
                    err_next = 1'b1;
                end
                if (pick_any) begin
                    grant_next = pick_idx;
                    state_next = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                // Write takes precedence when a requester raises both.
                wr_o     = wr_vec[grant_reg];
                rd_o     = rd_vec[grant_reg] & ~wr_vec[grant_reg];
                adr_o    = adr_arr[grant_reg];
                dat_re_o = re_arr[grant_reg];
                dat_im_o = im_arr[grant_reg];
                ack_vec[grant_reg] = ack_i;

                if (wr_vec[grant_reg] & rd_vec[grant_reg]) begin
                    err_next = 1'b1;
                end

                if (ack_i) begin
                    last_next  = grant_reg;
                    state_next = ARB_IDLE;
                end else if (!req_vec[grant_reg]) begin
                    // Request withdrawn before completion: abandon without
                    // advancing the round-robin pointer.
                    err_next   = 1'b1;
                    state_next = ARB_IDLE;
                end
            end

            default: begin
                state_next = ARB_IDLE;
            end
        endcase
    end

    assign err_o = err_reg;

endmodule

// File: tb/tb_bel_fft_mif_arb.sv
// ---------------------------------------------------------------------------
// tb_bel_fft_mif_arb
//   Directed-vector bench for bel_fft_mif_arb. Inputs are driven 1 time unit
//   after the rising edge, outputs are sampled 4 units after it.
// ---------------------------------------------------------------------------
module tb_bel_fft_mif_arb;

    localparam int AW = 10;
    localparam int WW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] adr [4];
    logic [WW-1:0] re  [4];
    logic [WW-1:0] im  [4];
    logic [3:0]    wr_v;
    logic [3:0]    rd_v;
    logic [3:0]    acks;
    logic          req_ack0, req_ack1, req_ack2, req_ack3;
    logic [WW-1:0] rd_re, rd_im;
    logic [AW-1:0] adr_o;
    logic [WW-1:0] dat_re_o, dat_im_o;
    logic          wr_o, rd_o, err_o;
    logic          ack_i;
    logic [WW-1:0] dat_re_i, dat_im_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign acks = {req_ack3, req_ack2, req_ack1, req_ack0};

    bel_fft_mif_arb #(.word_width(WW), .adr_width(AW)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_adr0_i (adr[0]), .req_re0_i (re[0]), .req_im0_i (im[0]),
        .req_wr0_i  (wr_v[0]), .req_rd0_i (rd_v[0]), .req_ack0_o (req_ack0),
        .req_adr1_i (adr[1]), .req_re1_i (re[1]), .req_im1_i (im[1]),
        .req_wr1_i  (wr_v[1]), .req_rd1_i (rd_v[1]), .req_ack1_o (req_ack1),
        .req_adr2_i (adr[2]), .req_re2_i (re[2]), .req_im2_i (im[2]),
        .req_wr2_i  (wr_v[2]), .req_rd2_i (rd_v[2]), .req_ack2_o (req_ack2),
        .req_adr3_i (adr[3]), .req_re3_i (re[3]), .req_im3_i (im[3]),
        .req_wr3_i  (wr_v[3]), .req_rd3_i (rd_v[3]), .req_ack3_o (req_ack3),
        .rd_re_o    (rd_re),
        .rd_im_o    (rd_im),
        .adr_o      (adr_o),
        .dat_re_o   (dat_re_o),
        .dat_im_o   (dat_im_o),
        .wr_o       (wr_o),
        .rd_o       (rd_o),
        .ack_i      (ack_i),
        .dat_re_i   (dat_re_i),
        .dat_im_i   (dat_im_i),
        .err_o      (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for a forwarded read from requester k, ack it after one
    // cycle, then check the dead IDLE cycle. drop clears all requests at the
    // end so the arbiter stays idle afterwards.
    task automatic serve(input int k, input bit drop);
        bit seen;
        seen = 1'b0;
        for (int c = 0; c < 8 && !seen; c++) begin
            step();
            #3;
            if (wr_o || rd_o) seen = 1'b1;
        end
        chk($sformatf("rr_fwd_seen_%0d", k), 64'(seen), 64'd1);
        chk($sformatf("rr_adr_%0d", k), 64'(adr_o), 64'(adr[k]));
        chk($sformatf("rr_rd_only_%0d", k), 64'({wr_o, rd_o}), 64'b01);
        step();
        ack_i    = 1'b1;
        dat_re_i = 32'h5000_0000 + 32'(k);
        #3;
        chk($sformatf("rr_ack_%0d", k), 64'(acks), 64'(4'b0001 << k));
        chk($sformatf("rr_rdre_%0d", k), 64'(rd_re), 64'(32'h5000_0000 + 32'(k)));
        step();
        ack_i = 1'b0;
        if (drop) rd_v = 4'b0000;
        #3;
        chk($sformatf("rr_dead_%0d", k), 64'({wr_o, rd_o, acks}), 64'd0);
    endtask

    initial begin
        rst      = 1'b1;
        wr_v     = 4'b0000;
        rd_v     = 4'b0000;
        ack_i    = 1'b0;
        dat_re_i = '0;
        dat_im_i = '0;
        for (int k = 0; k < 4; k++) begin
            adr[k] = '0;
            re[k]  = '0;
            im[k]  = '0;
        end

        // Reset state
        step();
        step();
        #3;
        chk("rst_wr_rd", 64'({wr_o, rd_o}), 64'd0);
        chk("rst_acks", 64'(acks), 64'd0);
        chk("rst_err", 64'(err_o), 64'd0);
        chk("rst_adr", 64'(adr_o), 64'd0);
        step();
        rst = 1'b0;

        // Single write, requester 2, MIF acks 2 cycles after forward
        step();
        wr_v[2] = 1'b1;
        adr[2]  = 10'h010;
        re[2]   = 32'h1111_2222;
        im[2]   = 32'h3333_4444;
        #3;
        chk("w2_idle_wr", 64'(wr_o), 64'd0);
        step();
        #3;
        chk("w2_fwd_wr", 64'(wr_o), 64'd1);
        chk("w2_fwd_rd", 64'(rd_o), 64'd0);
        chk("w2_adr", 64'(adr_o), 64'h010);
        chk("w2_re", 64'(dat_re_o), 64'h1111_2222);
        chk("w2_im", 64'(dat_im_o), 64'h3333_4444);
        chk("w2_acks_wait1", 64'(acks), 64'd0);
        step();
        #3;
        chk("w2_acks_wait2", 64'(acks), 64'd0);
        step();
        ack_i = 1'b1;
        #3;
        chk("w2_ack", 64'(acks), 64'b0100);
        step();
        ack_i   = 1'b0;
        wr_v[2] = 1'b0;
        #3;
        chk("w2_after_wr", 64'(wr_o), 64'd0);
        chk("w2_after_acks", 64'(acks), 64'd0);
        chk("w2_err", 64'(err_o), 64'd0);

        // Read, requester 0
        step();
        rd_v[0] = 1'b1;
        adr[0]  = 10'h020;
        #3;
        step();
        #3;
        chk("r0_rd", 64'(rd_o), 64'd1);
        chk("r0_adr", 64'(adr_o), 64'h020);
        step();
        ack_i    = 1'b1;
        dat_re_i = 32'hAAAA_0001;
        dat_im_i = 32'hBBBB_0002;
        #3;
        chk("r0_rd_re", 64'(rd_re), 64'hAAAA_0001);
        chk("r0_rd_im", 64'(rd_im), 64'hBBBB_0002);
        chk("r0_ack", 64'(acks), 64'b0001);
        step();
        ack_i   = 1'b0;
        rd_v[0] = 1'b0;
        #3;
        chk("r0_rd_drop", 64'(rd_o), 64'd0);

        // Requester 1 raises write and read together
        step();
        wr_v[1] = 1'b1;
        rd_v[1] = 1'b1;
        adr[1]  = 10'h030;
        #3;
        step();
        #3;
        chk("wr1_wr", 64'(wr_o), 64'd1);
        chk("wr1_rd", 64'(rd_o), 64'd0);
        chk("wr1_adr", 64'(adr_o), 64'h030);
        step();
        #3;
        chk("wr1_err_set", 64'(err_o), 64'd1);
        step();
        ack_i = 1'b1;
        #3;
        chk("wr1_ack", 64'(acks), 64'b0010);
        step();
        ack_i = 1'b0;
        wr_v  = 4'b0000;
        rd_v  = 4'b0000;
        #3;
        step();
        #3;
        chk("wr1_err_held", 64'(err_o), 64'd1);

        // Reset while a read is forwarded
        step();
        rd_v[1] = 1'b1;
        #3;
        step();
        #3;
        chk("rmid_rd_before", 64'(rd_o), 64'd1);
        step();
        rst   = 1'b1;
        ack_i = 1'b1;
        #3;
        chk("rmid_wr_rd", 64'({wr_o, rd_o}), 64'd0);
        chk("rmid_acks", 64'(acks), 64'd0);
        chk("rmid_err", 64'(err_o), 64'd0);

        // All four requesting continuously from reset release
        ack_i = 1'b0;
        rd_v  = 4'b1111;
        for (int k = 0; k < 4; k++) adr[k] = 10'(10'h100 + k);
        step();
        step();
        rst = 1'b0;
        serve(0, 1'b0);
        serve(1, 1'b0);
        serve(2, 1'b0);
        serve(3, 1'b0);
        serve(0, 1'b0);
        serve(1, 1'b1);
        chk("rr_err", 64'(err_o), 64'd0);

        // Requester 3 withdraws before ack (last stays at 1)
        step();
        rd_v[3] = 1'b1;
        #3;
        step();
        #3;
        chk("drop3_rd", 64'(rd_o), 64'd1);
        chk("drop3_adr", 64'(adr_o), 64'h103);
        step();
        rd_v[3] = 1'b0;
        #3;
        step();
        #3;
        chk("drop3_out0", 64'({wr_o, rd_o, adr_o}), 64'd0);
        chk("drop3_err", 64'(err_o), 64'd1);
        rd_v[0] = 1'b1;
        rd_v[3] = 1'b1;
        step();
        #3;
        chk("drop3_next_grant", 64'(adr_o), 64'h103);
        step();
        ack_i = 1'b1;
        #3;
        chk("drop3_next_ack", 64'(acks), 64'b1000);
        step();
        ack_i = 1'b0;
        rd_v  = 4'b0000;
        #3;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
